wave_sweep_sched: RTL and testbench
===================================

WAVE_SWEEP_SCHED -- requirements
Module: wave_sweep_sched

Interface
REQ-001 SHALL have parameter NX, default 16, lattice width in sites (power of two, >=4).
REQ-002 SHALL have parameter NY, default 16, lattice height in sites (power of two, >=4).
REQ-003 SHALL have parameter RD_LAT, default 1, cycles from rd_en to field data valid at the site inputs; ADDR_W = log2(NX*NY).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset (one clock, async active-high reset, decided).
REQ-005 SHALL have ports: start in 1 launch pulse; abort in 1 stop request; n_steps in 16 time steps to run; stall in 1 hold new issue.
REQ-006 SHALL have ports: rd_en out 1; rd_bank out 1; rd_addr_c, rd_addr_n, rd_addr_s, rd_addr_e, rd_addr_w out ADDR_W each, centre/neighbour read addresses.
REQ-007 SHALL have ports: site_enable out 1 drives the wave_site enable; site_valid in 1 from the wave_site valid_out.
REQ-008 SHALL have ports: wr_en out 1; wr_bank out 1; wr_addr out ADDR_W write-back of psi_next.
REQ-009 SHALL have ports: busy out 1; done out 1 completion pulse; aborted out 1 abort-complete pulse; step_cnt out 16 completed steps; err out 1 sticky sequencing error.

Function
REQ-010 SHALL implement FSM IDLE, SWEEP, DRAIN, SWAP, FINISH; busy=1 in every state except IDLE.
REQ-011 IDLE: start with n_steps>0 -> SWEEP, cell index=0, step_cnt=0; start with n_steps=0 -> FINISH; start outside IDLE SHALL be ignored.
REQ-012 SWEEP: each cycle with stall=0, rd_en=1 for current cell (x,y), index then increments raster order (x fastest); stall=1 -> rd_en=0, index held.
REQ-013 rd_addr_c = y*NX+x; neighbours SHALL wrap periodically: north y-1 mod NY, south y+1 mod NY, east x+1 mod NX, west x-1 mod NX.
REQ-014 After issuing cell NX*NY-1 the FSM SHALL go to DRAIN the next cycle.
REQ-015 site_enable SHALL equal rd_en delayed RD_LAT cycles.
REQ-016 A delay line of depth RD_LAT+4 SHALL carry {valid, rd_addr_c, rd_bank}; its output drives wr_en, wr_addr, wr_bank=~carried bank; the line always advances (never stalled).
REQ-017 DRAIN: exit to SWAP when delay line holds no valid entries.
REQ-018 SWAP (1 cycle): rd_bank toggles, step_cnt increments; if new step_cnt==n_steps -> FINISH else SWEEP with index 0.
REQ-019 FINISH (1 cycle): done=1 -> IDLE.
REQ-020 abort in SWEEP SHALL stop issue that cycle and go DRAIN; after drain -> IDLE with aborted=1 one cycle, no done, step_cnt/rd_bank unchanged; abort in DRAIN/SWAP SHALL be latched and take the same exit.
REQ-021 n_steps SHALL be sampled at start; later changes ignored.
REQ-022 start and abort same cycle in IDLE: start wins; abort in IDLE ignored.

Reset
REQ-023 On rst: FSM IDLE, index 0, delay line cleared, rd_bank 0, step_cnt 0, all outputs 0.
REQ-024 rst mid-sweep SHALL abandon in-flight writes immediately (wr_en=0 next edge); no done/aborted pulse.

Configuration
REQ-025 Macro WAVE_SWEEP_SCHED_CHECK_EN: defined -> each cycle site_valid SHALL be compared to the delay-line valid tap at depth RD_LAT+4; mismatch sets err (sticky until rst).
REQ-026 Without WAVE_SWEEP_SCHED_CHECK_EN: err tied 0, site_valid unused.

Verification
REQ-027 NX=NY=4, RD_LAT=1, n_steps=1, start -> 16 rd_en cycles, first wr_en 5 cycles after first rd_en, 16 writes to bank 1, done 1 cycle, step_cnt=1.
REQ-028 Cell (0,0) on 4x4 -> rd_addr_n=12, s=4, e=1, w=3; cell (3,3) -> n=11, s=3, e=12, w=14.
REQ-029 n_steps=3 -> rd_bank sequence 0,1,0 per sweep, final rd_bank=1, step_cnt=3, one done pulse; n_steps=0 -> done 2 cycles after start, no rd_en.
REQ-030 stall high 3 cycles mid-sweep -> no rd_en, index held, in-flight writes continue; total 16 writes; abort at cell 7 -> 8 writes, aborted pulse, no done.
REQ-031 With CHECK_EN, force site_valid low one cycle where wr_en=1 -> err=1 and stays until rst; rst mid-sweep -> wr_en=0 next cycle, busy=0.

Source files
------------

// File: rtl/wave_sweep_sched.sv
// wave_sweep_sched: raster sweep scheduler for a periodic 2-D wave lattice.
// Issues centre and neighbour reads per site, tracks in-flight results through
// a fixed-latency delay line, writes them back to the opposite bank, and
// ping-pongs the banks between time steps.
// Optional build macro WAVE_SWEEP_SCHED_CHECK_EN: checks site_valid against the
// expected valid timing and raises a sticky err on any disagreement.
module wave_sweep_sched #(
    parameter int unsigned NX     = 16,
    parameter int unsigned NY     = 16,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned ADDR_W = $clog2(NX * NY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       n_steps,
    input  logic              stall,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr_c,
    output logic [ADDR_W-1:0] rd_addr_n,
    output logic [ADDR_W-1:0] rd_addr_s,
    output logic [ADDR_W-1:0] rd_addr_e,
    output logic [ADDR_W-1:0] rd_addr_w,
    output logic              site_enable,
    input  logic              site_valid,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       step_cnt,
    output logic              err
);

    localparam int unsigned XW    = $clog2(NX);
    localparam int unsigned YW    = $clog2(NY);
    localparam int          DEPTH = int'(RD_LAT) + 4;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NX * NY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSweep,
        StDrain,
        StSwap,
        StFinish
    } state_t;

    // One in-flight site result: where it came from and which bank it read.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              bank;
    } dl_entry_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       n_steps_q;
    logic              abort_q;
    dl_entry_t         line [DEPTH];
    logic              pending;

    // Coordinates of the cell about to be issued and its wrapped neighbours.
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [XW-1:0] x_p;
    logic [XW-1:0] x_m;
    logic [YW-1:0] y_p;
    logic [YW-1:0] y_m;

    // Power-of-two lattice: modular wrap falls out of plain truncating arithmetic.
    always_comb begin
        cur_x = idx[XW-1:0];
        cur_y = idx[ADDR_W-1:XW];
        x_p   = cur_x + XW'(1);
        x_m   = cur_x - XW'(1);
        y_p   = cur_y + YW'(1);
        y_m   = cur_y - YW'(1);
    end

    // Anything still travelling from read issue to write-back, including the
    // issue register itself, keeps DRAIN from exiting.
    always_comb begin
        pending = rd_en;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | line[i].valid;
        end
    end

    // Sequencer FSM with registered read-side and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            idx       <= '0;
            n_steps_q <= '0;
            abort_q   <= 1'b0;
            rd_en     <= 1'b0;
            rd_bank   <= 1'b0;
            rd_addr_c <= '0;
            rd_addr_n <= '0;
            rd_addr_s <= '0;
            rd_addr_e <= '0;
            rd_addr_w <= '0;
            step_cnt  <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            rd_en   <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                StIdle: begin
                    // abort is ignored here, so start always wins a tie
                    if (start) begin
                        n_steps_q <= n_steps;
                        step_cnt  <= '0;
                        idx       <= '0;
                        abort_q   <= 1'b0;
                        state     <= (n_steps == 16'd0) ? StFinish : StSweep;
                    end
                end
                StSweep: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                        state   <= StDrain;
                    end else if (!stall) begin
                        rd_en     <= 1'b1;
                        rd_addr_c <= idx;
                        rd_addr_n <= {y_m, cur_x};
                        rd_addr_s <= {y_p, cur_x};
                        rd_addr_e <= {cur_y, x_p};
                        rd_addr_w <= {cur_y, x_m};
                        idx       <= idx + ADDR_W'(1);
                        if (idx == LAST_CELL) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (!pending) begin
                        if (abort_q || abort) begin
                            abort_q <= 1'b0;
                            aborted <= 1'b1;
                            state   <= StIdle;
                        end else begin
                            state <= StSwap;
                        end
                    end
                end
                StSwap: begin
                    // An abort landing here leaves bank and step count untouched.
                    if (abort_q || abort) begin
                        abort_q <= 1'b0;
                        aborted <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        rd_bank  <= ~rd_bank;
                        step_cnt <= step_cnt + 16'd1;
                        idx      <= '0;
                        state    <= (step_cnt + 16'd1 == n_steps_q) ? StFinish : StSweep;
                    end
                end
                StFinish: begin
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Free-running delay line from read issue to write-back; never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= '{valid: rd_en, addr: rd_addr_c, bank: rd_bank};
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign busy    = (state != StIdle);
    assign wr_en   = line[DEPTH-1].valid;
    assign wr_addr = line[DEPTH-1].addr;
    assign wr_bank = ~line[DEPTH-1].bank;

    generate
        if (RD_LAT == 0) begin : g_se_direct
            assign site_enable = rd_en;
        end else begin : g_se_tap
            assign site_enable = line[RD_LAT-1].valid;
        end
    endgenerate

`ifdef WAVE_SWEEP_SCHED_CHECK_EN
    // Sticky flag: the site pipeline's valid must track the scheduler's tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (site_valid != line[DEPTH-1].valid) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_site_valid;
    assign unused_site_valid = site_valid;
    assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_wave_sweep_sched.sv
// Directed bench for wave_sweep_sched on a 4x4 lattice with RD_LAT=1.
module tb_wave_sweep_sched;

    localparam int NX     = 4;
    localparam int NY     = 4;
    localparam int RD_LAT = 1;
    localparam int AW     = 4;
    localparam int CELLS  = NX * NY;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [15:0]   n_steps;
    logic          stall;
    logic          rd_en;
    logic          rd_bank;
    logic [AW-1:0] rd_addr_c;
    logic [AW-1:0] rd_addr_n;
    logic [AW-1:0] rd_addr_s;
    logic [AW-1:0] rd_addr_e;
    logic [AW-1:0] rd_addr_w;
    logic          site_enable;
    logic          site_valid;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [15:0]   step_cnt;
    logic          err;
    logic          bad;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // A well-behaved site pipeline; bad knocks out one valid on demand.
    assign site_valid = wr_en & ~bad;

    wave_sweep_sched #(
        .NX    (NX),
        .NY    (NY),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .n_steps    (n_steps),
        .stall      (stall),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr_c  (rd_addr_c),
        .rd_addr_n  (rd_addr_n),
        .rd_addr_s  (rd_addr_s),
        .rd_addr_e  (rd_addr_e),
        .rd_addr_w  (rd_addr_w),
        .site_enable(site_enable),
        .site_valid (site_valid),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .step_cnt   (step_cnt),
        .err        (err)
    );

    typedef struct {
        int n;
        int stall_at;
        int abort_at;
        int restart_at;
        int exp_rd;
        int exp_wr;
        int exp_done;
        int exp_ab;
        int exp_step;
        int exp_bank;
        int exp_gap;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        stall   = 1'b0;
        bad     = 1'b0;
        n_steps = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_wr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (wr_en) ok = 1'b1;
        end
    endtask

    // One launch, watched cycle by cycle against a raster-order model.
    task automatic run_vec(input vec_t v, input int k);
        int  rd_cnt, wr_cnt, done_cnt, ab_cnt, gap, tail, stall_left;
        int  first_rd, first_wr, first_se, c, x, y;
        bit  finished, abort_sent;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; ab_cnt = 0; gap = 0; tail = 0;
        stall_left = 0; first_rd = -1; first_wr = -1; first_se = -1;
        finished = 1'b0; abort_sent = 1'b0;
        do_reset();
        n_steps = 16'(v.n);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n_steps = 16'hFFFF;  // must not affect a sweep already launched
        for (int cyc = 1; cyc < 1000 && !finished; cyc++) begin
            if (rd_en) begin
                c = rd_cnt % CELLS;
                x = c % NX;
                y = c / NX;
                check($sformatf("v%0d rd_addr_c", k), int'(rd_addr_c), c);
                check($sformatf("v%0d rd_addr_n", k), int'(rd_addr_n), ((y + NY - 1) % NY) * NX + x);
                check($sformatf("v%0d rd_addr_s", k), int'(rd_addr_s), ((y + 1) % NY) * NX + x);
                check($sformatf("v%0d rd_addr_e", k), int'(rd_addr_e), y * NX + (x + 1) % NX);
                check($sformatf("v%0d rd_addr_w", k), int'(rd_addr_w), y * NX + (x + NX - 1) % NX);
                check($sformatf("v%0d rd_bank", k), int'(rd_bank), (rd_cnt / CELLS) % 2);
                if (first_rd < 0) first_rd = cyc;
                rd_cnt++;
            end
            if (site_enable && first_se < 0) first_se = cyc;
            if (wr_en) begin
                check($sformatf("v%0d wr_addr", k), int'(wr_addr), wr_cnt % CELLS);
                check($sformatf("v%0d wr_bank", k), int'(wr_bank), 1 - (wr_cnt / CELLS) % 2);
                if (first_wr < 0) first_wr = cyc;
                wr_cnt++;
            end
            if (done) done_cnt++;
            if (aborted) ab_cnt++;
            if (first_rd >= 0 && rd_cnt < CELLS && !abort_sent && !rd_en) gap++;
            // drive inputs for the next edge
            abort = 1'b0;
            if (v.abort_at > 0 && rd_en && rd_cnt == v.abort_at && !abort_sent) begin
                abort      = 1'b1;
                abort_sent = 1'b1;
            end
            if (v.stall_at > 0 && rd_en && rd_cnt == v.stall_at) stall_left = 3;
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                stall = 1'b0;
            end
            if (v.restart_at > 0 && rd_en && rd_cnt == v.restart_at) begin
                start   = 1'b1;
                n_steps = 16'd7;
            end else begin
                start   = 1'b0;
                n_steps = 16'hFFFF;
            end
            if ((done_cnt + ab_cnt) > 0 && !busy) tail++;
            if (tail == 4) finished = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        if (!finished) check($sformatf("v%0d timeout", k), 0, 1);
        check($sformatf("v%0d rd count", k), rd_cnt, v.exp_rd);
        check($sformatf("v%0d wr count", k), wr_cnt, v.exp_wr);
        check($sformatf("v%0d done pulses", k), done_cnt, v.exp_done);
        check($sformatf("v%0d aborted pulses", k), ab_cnt, v.exp_ab);
        check($sformatf("v%0d step_cnt", k), int'(step_cnt), v.exp_step);
        check($sformatf("v%0d final rd_bank", k), int'(rd_bank), v.exp_bank);
        check($sformatf("v%0d stall gap", k), gap, v.exp_gap);
        check($sformatf("v%0d err", k), int'(err), 0);
        if (v.exp_rd > 0) begin
            check($sformatf("v%0d rd->wr latency", k), first_wr - first_rd, RD_LAT + 4);
            check($sformatf("v%0d rd->site_enable latency", k), first_se - first_rd, RD_LAT);
        end
    endtask

    initial begin
        bit ok;
        int dcnt, acnt;

        //         n  stall abort restart rd  wr  done ab step bank gap
        tbl[0] = '{1, 0,    0,    10,     16, 16, 1,   0, 1,   1,   0};
        tbl[1] = '{3, 0,    0,    0,      48, 48, 1,   0, 3,   1,   0};
        tbl[2] = '{1, 5,    0,    0,      16, 16, 1,   0, 1,   1,   3};
        tbl[3] = '{1, 0,    8,    0,      8,  8,  0,   1, 0,   0,   0};
        tbl[4] = '{2, 0,    20,   0,      20, 20, 0,   1, 1,   1,   0};
        tbl[5] = '{0, 0,    0,    0,      0,  0,  1,   0, 0,   0,   0};

        @(negedge clk);
        do_reset();
        check("reset busy", int'(busy), 0);
        check("reset rd_en", int'(rd_en), 0);
        check("reset wr_en", int'(wr_en), 0);
        check("reset site_enable", int'(site_enable), 0);
        check("reset done", int'(done), 0);
        check("reset aborted", int'(aborted), 0);
        check("reset step_cnt", int'(step_cnt), 0);
        check("reset rd_bank", int'(rd_bank), 0);
        check("reset err", int'(err), 0);

        for (int k = 0; k < 6; k++) begin
            run_vec(tbl[k], k);
        end

        // Zero steps: done two cycles after the start cycle, busy only in between.
        do_reset();
        n_steps = 16'd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("n0 busy +1", int'(busy), 1);
        check("n0 done +1", int'(done), 0);
        @(negedge clk);
        check("n0 done +2", int'(done), 1);
        check("n0 busy +2", int'(busy), 0);
        @(negedge clk);
        check("n0 done +3", int'(done), 0);

        // abort alone in IDLE does nothing; start+abort together launches normally.
        do_reset();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle abort busy", int'(busy), 0);
        @(negedge clk);
        check("idle abort pulse", int'(aborted), 0);
        n_steps = 16'd1;
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", int'(busy), 1);
        dcnt = 0;
        acnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) dcnt++;
            if (aborted) acnt++;
            @(negedge clk);
        end
        check("start+abort done", dcnt, 1);
        check("start+abort aborted", acnt, 0);

        // Reset mid-sweep drops in-flight writes at once and emits no pulses.
        do_reset();
        n_steps = 16'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_wr(ok);
        check("rst-mid wr seen", int'(ok), 1);
        rst = 1'b1;
        #1;
        check("rst-mid wr_en", int'(wr_en), 0);
        check("rst-mid busy", int'(busy), 0);
        check("rst-mid rd_en", int'(rd_en), 0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        acnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (aborted) acnt++;
            if (wr_en) dcnt++;
        end
        check("rst-mid done/wr after", dcnt, 0);
        check("rst-mid aborted after", acnt, 0);
        check("rst-mid step_cnt", int'(step_cnt), 0);

`ifdef WAVE_SWEEP_SCHED_CHECK_EN
        // Drop site_valid for one cycle while a write is due: err latches.
        do_reset();
        n_steps = 16'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_wr(ok);
        check("chk wr seen", int'(ok), 1);
        check("chk err before", int'(err), 0);
        bad = 1'b1;
        @(negedge clk);
        bad = 1'b0;
        check("chk err set", int'(err), 1);
        repeat (30) @(negedge clk);
        check("chk err sticky", int'(err), 1);
        do_reset();
        check("chk err cleared", int'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
